// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, status-flag bit positions
// and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_INC = 4'd13;
    localparam logic [3:0] OP_DEC = 4'd14;
    localparam logic [3:0] OP_ADC = 4'd15;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic z, input logic c);
        logic [3:0] f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// done asserts once the iteration counter has run down to zero.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     sum;

    // Upper half accumulates; the multiplier shifts out of the lower half.
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        count_d = count_q;
        busy_d  = busy_q;
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (start) begin
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            count_d = CW'(WIDTH);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q != '0) begin
                prod_d  = {sum, prod_q[WIDTH-1:1]};
                count_d = count_q - CW'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign done    = busy_q && (count_q == '0);
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready input handshake and status flags.
//   state   | meaning
//   ST_IDLE | ready, waiting for in_valid
//   ST_EXEC | single-cycle op latched, result registered on next edge
//   ST_MUL  | multiplier iterating, result registered when it reports done
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        function_select_lines,
    output logic              out_valid,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_high,
    output logic [3:0]        sreg
);

    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_high_q, result_high_d;
    logic [3:0]         sreg_q, sreg_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [SHW-1:0]     sh;
    logic [SHW:0]       sh_inv;
    logic [WIDTH-1:0]   add_b, sub_b;
    logic               add_cin;
    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH:0]     shl_w, shr_w, sar_w;
    logic [WIDTH-1:0]   rol_r, ror_r;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (function_select_lines == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // INC/DEC reuse the adder/subtractor with an implicit operand of one.
    always_comb begin
        sh      = b_q[SHW-1:0];
        sh_inv  = (SHW+1)'(WIDTH) - {1'b0, sh};
        add_b   = (op_q == OP_INC) ? WIDTH'(1) : b_q;
        sub_b   = (op_q == OP_DEC) ? WIDTH'(1) : b_q;
        add_cin = (op_q == OP_ADC) ? sreg_q[FLG_C] : 1'b0;
        add_w   = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        sub_w   = {1'b0, a_q} - {1'b0, sub_b};
        shl_w   = {1'b0, a_q} << sh;
        shr_w   = {a_q, 1'b0} >> sh;
        sar_w   = $signed({a_q, 1'b0}) >>> sh;
        rol_r   = (a_q << sh) | (a_q >> sh_inv);
        ror_r   = (a_q >> sh) | (a_q << sh_inv);
    end

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC, OP_INC: begin
                alu_r = add_w[MSB:0];
                alu_c = add_w[WIDTH];
                alu_v = (a_q[MSB] == add_b[MSB]) && (add_w[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_DEC: begin
                alu_r = sub_w[MSB:0];
                alu_c = sub_w[WIDTH];
                alu_v = (a_q[MSB] != sub_b[MSB]) && (sub_w[MSB] != a_q[MSB]);
            end
            OP_AND: alu_r = a_q & b_q;
            OP_OR:  alu_r = a_q | b_q;
            OP_XOR: alu_r = a_q ^ b_q;
            OP_NOT: alu_r = ~a_q;
            OP_SHL: begin
                alu_r = shl_w[MSB:0];
                alu_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_r = shr_w[WIDTH:1];
                alu_c = shr_w[0];
            end
            OP_SAR: begin
                alu_r = sar_w[WIDTH:1];
                alu_c = sar_w[0];
            end
            OP_ROL: begin
                alu_r = rol_r;
                alu_c = (sh != '0) && rol_r[0];
            end
            OP_ROR: begin
                alu_r = ror_r;
                alu_c = (sh != '0) && ror_r[MSB];
            end
            OP_CMP: begin
                alu_r[2] = (a_q > b_q);
                alu_r[1] = (a_q == b_q);
                alu_r[0] = (a_q < b_q);
            end
            default: begin
                alu_r = '0;
                alu_c = 1'b0;
                alu_v = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        result_d      = result_q;
        result_high_d = result_high_q;
        sreg_d        = sreg_q;
        out_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = function_select_lines;
                    state_d = (function_select_lines == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d      = alu_r;
                result_high_d = '0;
                sreg_d        = pack_flags(alu_v, alu_r[MSB], alu_r == '0, alu_c);
                out_valid_d   = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d      = mul_product[MSB:0];
                    result_high_d = mul_product[2*WIDTH-1:WIDTH];
                    sreg_d        = pack_flags(1'b0, mul_product[2*WIDTH-1],
                                               mul_product == '0,
                                               mul_product[2*WIDTH-1:WIDTH] != '0);
                    out_valid_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            result_q      <= '0;
            result_high_q <= '0;
            sreg_q        <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            result_q      <= result_d;
            result_high_q <= result_high_d;
            sreg_q        <= sreg_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_high = result_high_q;
    assign sreg        = sreg_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit ALU: WIDTH-bit operands, 16 operations selected by a 4-bit function code, 4-bit status register.
- Adds a valid/ready input handshake, registered outputs, an iterative shift-add multiplier (multi-cycle) and carry-chained ADC using the stored carry flag.
- Sits between the datapath register file and the writeback stage; accepts one operation at a time.

Parameters:
- WIDTH, 8, operand/result width; power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override).

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when an op can be accepted (state IDLE).
- a  in  WIDTH  operand A, sampled at acceptance.
- b  in  WIDTH  operand B, sampled at acceptance.
- function_select_lines  in  4  opcode, sampled at acceptance.
- out_valid  out  1  one-cycle pulse when result/result_high/sreg update.
- result  out  WIDTH  result (MUL: low half).
- result_high  out  WIDTH  MUL high half; 0 for all other ops.
- sreg  out  4  flags {V,N,Z,C} = bits [3:0] as V=3, N=2, Z=1, C=0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1 after release, out_valid=0, result=0, result_high=0, sreg=0. Reset mid-MUL aborts the op; no out_valid.
- Acceptance: rising edge with in_valid & in_ready. Inputs latched; later changes ignored.
- in_valid while busy: ignored, not buffered.
- No output backpressure.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 MUL (unsigned), 3 AND, 4 OR, 5 XOR, 6 NOT A.
  - 7 SHL, 8 SHR (logical), 9 SAR, 10 ROL, 11 ROR; shift/rotate amount = b[SHW-1:0].
  - 12 CMP: result = {0…, A>B, A==B, A<B}, unsigned.
  - 13 INC A, 14 DEC A, 15 ADC (A+B+sreg.C).
- States: IDLE → EXEC on non-MUL accept; IDLE → MUL on MUL accept; EXEC → IDLE; MUL → IDLE when the counter reaches 0.
- Single-cycle ops: accept at edge k; outputs registered at edge k+1; out_valid high for the cycle after edge k+1.
- in_ready is low exactly one cycle (EXEC), so back-to-back throughput is one op per 2 cycles.
- MUL:
  - Counter loaded with WIDTH; one shift-add iteration per cycle.
  - Product written and out_valid pulsed at edge k+WIDTH+1.
  - in_ready low throughout.
- Flags, computed on the final result:
  - Z = (result==0), and for MUL also result_high==0.
  - N = MSB of result (MUL: MSB of result_high).
  - C = carry-out for ADD/ADC/INC; borrow (A<B) for SUB/DEC; last bit shifted out for shifts/rotates (0 if amount 0); result_high≠0 for MUL; 0 otherwise.
  - V = signed overflow for ADD/SUB/ADC/INC/DEC; 0 otherwise.
- Outputs and sreg hold until the next completion; sreg.C used by ADC is the held value.
- All arithmetic modulo 2^WIDTH except the MUL full 2·WIDTH product.

Decomposition:
- Package alu_pkg:
  - Opcode localparams (OP_ADD … OP_ADC).
  - Flag bit indices (FLG_C/Z/N/V).
  - FSM state encoding (IDLE, EXEC, MUL).
- Sub-module alu_seq_mul:
  - Iterative unsigned multiplier with ports clk, rst_n, start, a, b, done, product[2·WIDTH-1:0].
  - Owns the counter.
  - Top level holds the FSM, single-cycle datapath and flag logic.

Test Plan (WIDTH=8 unless noted):
- ADD a=127 b=125 → result 0xFC, sreg V=1 N=1 Z=0 C=0; out_valid one cycle after the edge following acceptance.
- MUL a=255 b=255 → result_high 0xFE, result 0x01, C=1, out_valid at accept+9 edges. A second in_valid (ADD 1,1) during busy sees in_ready=0, is dropped, and produces no extra out_valid.
- SUB 5−5 → 0, Z=1 C=0; ADD 0xFF+0x01 → 0x00, C=1 Z=1; then ADC 0+0 → 0x01 C=0 (carry consumed).
- ROL a=0x81 b=9 (amount 1) → 0x03, C=1; SAR a=0x80 b=3 → 0xF0, N=1; CMP a=13 b=85 → 0x01.
- rst_n pulsed low 4 cycles into MUL → all outputs 0 immediately (asynchronous); in_ready=1 after release; no out_valid.
- WIDTH=16: MUL 0xFFFF×0x0002 → high 0x0001, low 0xFFFE, latency 17 edges; DEC 0x0000 → 0xFFFF, C=1 N=1.
